// File: rtl/tagged_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tagged_regfile_pkg
//  Description : Shared widths, address-width helper, read-entry field
//                offsets and entry struct for the tagged register file.
//                Entry layout on the read bus, MSB to LSB: {data, busy, tag}.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package tagged_regfile_pkg;

    localparam int C_DATA_W = 16;
    localparam int C_TAG_W  = 6;

    // Register address width for a power-of-two register count.
    function automatic int trf_aw(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int trf_entry_w(input int data_w, input int tag_w);
        return data_w + 1 + tag_w;
    endfunction

    function automatic int trf_tag_lsb();
        return 0;
    endfunction

    function automatic int trf_busy_bit(input int tag_w);
        return tag_w;
    endfunction

    function automatic int trf_data_lsb(input int tag_w);
        return tag_w + 1;
    endfunction

    // Entry at the default widths.
    typedef struct packed {
        logic [C_DATA_W-1:0] data;
        logic                busy;
        logic [C_TAG_W-1:0]  tag;
    } trf_entry_t;

endpackage
`default_nettype wire

// File: rtl/trf_bypass_mux.sv
`default_nettype none
// ============================================================================
//  Module      : trf_bypass_mux
//  Description : Per-read-port output stage. Takes the registered read
//                address and the stored entry, and forwards a same-cycle
//                writeback whose register and tag both match (lowest
//                writeback port wins). The stored tag is always passed on.
//  Ports       : addr      - registered read address
//                st_*      - stored data / busy / tag of that register
//                wb_*      - writeback buses (same layout as the top level)
//                entry     - final {data, busy, tag}
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module trf_bypass_mux
    import tagged_regfile_pkg::*;
#(
    parameter int AW       = 3,
    parameter int DATA_W   = C_DATA_W,
    parameter int TAG_W    = C_TAG_W,
    parameter int NWB      = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int C_EW    = trf_entry_w(DATA_W, TAG_W)
) (
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic                  st_busy,
    input  logic [TAG_W-1:0]      st_tag,
    input  logic [NWB-1:0]        wb_en,
    input  logic [NWB*AW-1:0]     wb_reg,
    input  logic [NWB*DATA_W-1:0] wb_data,
    input  logic [NWB*TAG_W-1:0]  wb_tag,
    output logic [C_EW-1:0]       entry
);

    localparam int C_TAG_LSB  = trf_tag_lsb();
    localparam int C_BUSY_BIT = trf_busy_bit(TAG_W);
    localparam int C_DATA_LSB = trf_data_lsb(TAG_W);

    logic              w_is_zero;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_is_zero = (ZERO_REG != 0) && (addr == '0);

    // Walk from the highest port down so the lowest matching port ends up
    // owning the output.
    always_comb begin
        w_data = st_data;
        w_busy = st_busy;
        for (int j = NWB - 1; j >= 0; j--) begin
            if ((BYPASS != 0) && !w_is_zero && wb_en[j] &&
                (wb_reg[j*AW +: AW] == addr) &&
                (wb_tag[j*TAG_W +: TAG_W] == st_tag)) begin
                w_data = wb_data[j*DATA_W +: DATA_W];
                w_busy = 1'b0;
            end
        end
    end

    always_comb begin
        entry = '0;
        if (!w_is_zero) begin
            entry[C_DATA_LSB +: DATA_W] = w_data;
            entry[C_BUSY_BIT]           = w_busy;
            entry[C_TAG_LSB +: TAG_W]   = st_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tagged_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tagged_regfile
//  Description : Architectural register file with rename tags. Each register
//                holds {data, busy, tag}. Rename allocates (sets tag, busy),
//                writeback writes data and clears busy on a tag match, flush
//                clears every busy bit. Reads are registered-address with an
//                optional same-cycle writeback bypass.
//  Ports       : clk, reset (sync, active-high), flush
//                raddr/rdata     - NRD read ports, rdata = {data,busy,tag}
//                al_en/reg/tag   - NALLOC allocate ports (higher = younger)
//                wb_en/reg/data/tag - NWB writeback ports
//                busy_vec        - registered busy bit of every register
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module tagged_regfile
    import tagged_regfile_pkg::*;
#(
    parameter int NREGS    = 8,
    parameter int DATA_W   = C_DATA_W,
    parameter int TAG_W    = C_TAG_W,
    parameter int NRD      = 8,
    parameter int NALLOC   = 4,
    parameter int NWB      = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int C_AW    = trf_aw(NREGS),
    localparam int C_EW    = trf_entry_w(DATA_W, TAG_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NRD*C_AW-1:0]   raddr,
    output logic [NRD*C_EW-1:0]   rdata,
    input  logic [NALLOC-1:0]     al_en,
    input  logic [NALLOC*C_AW-1:0] al_reg,
    input  logic [NALLOC*TAG_W-1:0] al_tag,
    input  logic [NWB-1:0]        wb_en,
    input  logic [NWB*C_AW-1:0]   wb_reg,
    input  logic [NWB*DATA_W-1:0] wb_data,
    input  logic [NWB*TAG_W-1:0]  wb_tag,
    output logic [NREGS-1:0]      busy_vec
);

    logic [DATA_W-1:0]   r_data [NREGS];
    logic [TAG_W-1:0]    r_tag  [NREGS];
    logic [NREGS-1:0]    r_busy;
    logic [NRD*C_AW-1:0] r_raddr;

    // Register 0 is read-only when it is the hardwired zero register.
    function automatic logic writable(input logic [C_AW-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Statement order encodes same-register priority: writeback busy-clear,
    // then allocate, then flush. Later non-blocking writes override earlier
    // ones, which also makes the highest writeback / allocate port win.
    // Tag compares read r_tag, i.e. the value before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_data[r] <= '0;
                r_tag[r]  <= '0;
            end
            r_busy  <= '0;
            r_raddr <= '0;
        end else begin
            r_raddr <= raddr;
            for (int j = 0; j < NWB; j++) begin
                if (wb_en[j] && writable(wb_reg[j*C_AW +: C_AW])) begin
                    r_data[wb_reg[j*C_AW +: C_AW]] <= wb_data[j*DATA_W +: DATA_W];
                    if (r_tag[wb_reg[j*C_AW +: C_AW]] == wb_tag[j*TAG_W +: TAG_W]) begin
                        r_busy[wb_reg[j*C_AW +: C_AW]] <= 1'b0;
                    end
                end
            end
            for (int i = 0; i < NALLOC; i++) begin
                if (al_en[i] && writable(al_reg[i*C_AW +: C_AW])) begin
                    r_tag[al_reg[i*C_AW +: C_AW]]  <= al_tag[i*TAG_W +: TAG_W];
                    r_busy[al_reg[i*C_AW +: C_AW]] <= 1'b1;
                end
            end
            if (flush) begin
                r_busy <= '0;
            end
        end
    end

    assign busy_vec = r_busy;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            trf_bypass_mux #(
                .AW       (C_AW),
                .DATA_W   (DATA_W),
                .TAG_W    (TAG_W),
                .NWB      (NWB),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_mux (
                .addr    (r_raddr[k*C_AW +: C_AW]),
                .st_data (r_data[r_raddr[k*C_AW +: C_AW]]),
                .st_busy (r_busy[r_raddr[k*C_AW +: C_AW]]),
                .st_tag  (r_tag[r_raddr[k*C_AW +: C_AW]]),
                .wb_en   (wb_en),
                .wb_reg  (wb_reg),
                .wb_data (wb_data),
                .wb_tag  (wb_tag),
                .entry   (rdata[k*C_EW +: C_EW])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tagged_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tagged_regfile
//  Description : Self-checking bench. Two default-size files (bypass on/off)
//                share one stimulus stream and one rule-level reference
//                model; a third, 32x32 zero-register instance gets directed
//                checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tagged_regfile;

    localparam int NR = 8, AW = 3, DW = 16, TW = 6, EW = 23;
    localparam int NRD = 8, NAL = 4, NWB = 3;
    localparam int NRC = 32, AWC = 5, DWC = 32, EWC = 39;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;
    logic [NRD*AW-1:0]  raddr;
    logic [NRD*EW-1:0]  rdata_a, rdata_b;
    logic [NAL-1:0]     al_en;
    logic [NAL*AW-1:0]  al_reg;
    logic [NAL*TW-1:0]  al_tag;
    logic [NWB-1:0]     wb_en;
    logic [NWB*AW-1:0]  wb_reg;
    logic [NWB*DW-1:0]  wb_data;
    logic [NWB*TW-1:0]  wb_tag;
    logic [NR-1:0]      busy_vec_a, busy_vec_b;

    logic               flush_c;
    logic [NRD*AWC-1:0] raddr_c;
    logic [NRD*EWC-1:0] rdata_c;
    logic [NAL-1:0]     al_en_c;
    logic [NAL*AWC-1:0] al_reg_c;
    logic [NAL*TW-1:0]  al_tag_c;
    logic [NWB-1:0]     wb_en_c;
    logic [NWB*AWC-1:0] wb_reg_c;
    logic [NWB*DWC-1:0] wb_data_c;
    logic [NWB*TW-1:0]  wb_tag_c;
    logic [NRC-1:0]     busy_vec_c;

    tagged_regfile #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .raddr(raddr), .rdata(rdata_a),
        .al_en(al_en), .al_reg(al_reg), .al_tag(al_tag),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .wb_tag(wb_tag),
        .busy_vec(busy_vec_a));

    tagged_regfile #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .raddr(raddr), .rdata(rdata_b),
        .al_en(al_en), .al_reg(al_reg), .al_tag(al_tag),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .wb_tag(wb_tag),
        .busy_vec(busy_vec_b));

    tagged_regfile #(.NREGS(NRC), .DATA_W(DWC), .ZERO_REG(1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush_c), .raddr(raddr_c), .rdata(rdata_c),
        .al_en(al_en_c), .al_reg(al_reg_c), .al_tag(al_tag_c),
        .wb_en(wb_en_c), .wb_reg(wb_reg_c), .wb_data(wb_data_c), .wb_tag(wb_tag_c),
        .busy_vec(busy_vec_c));

    // Reference model state for the default-size files.
    logic [DW-1:0] m_data  [NR];
    logic          m_busy  [NR];
    logic [TW-1:0] m_tag   [NR];
    logic [AW-1:0] m_raddr [NRD];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Next state from the rules: data = last writeback to the register,
    // busy = flush ? 0 : any allocate ? 1 : any tag-matching writeback ? 0 : old.
    task automatic model_step();
        logic [DW-1:0] nd [NR];
        logic          nb [NR];
        logic [TW-1:0] nt [NR];
        bit            alloc, clr;
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
            for (int k = 0; k < NRD; k++) m_raddr[k] = '0;
            return;
        end
        for (int r = 0; r < NR; r++) begin
            alloc = 0; clr = 0;
            nd[r] = m_data[r];
            nt[r] = m_tag[r];
            for (int j = 0; j < NWB; j++) begin
                if (wb_en[j] && wb_reg[j*AW +: AW] == r) begin
                    nd[r] = wb_data[j*DW +: DW];
                    if (wb_tag[j*TW +: TW] == m_tag[r]) clr = 1;
                end
            end
            for (int i = 0; i < NAL; i++) begin
                if (al_en[i] && al_reg[i*AW +: AW] == r) begin
                    alloc = 1;
                    nt[r] = al_tag[i*TW +: TW];
                end
            end
            nb[r] = flush ? 1'b0 : alloc ? 1'b1 : clr ? 1'b0 : m_busy[r];
        end
        for (int r = 0; r < NR; r++) begin
            m_data[r] = nd[r]; m_busy[r] = nb[r]; m_tag[r] = nt[r];
        end
        for (int k = 0; k < NRD; k++) m_raddr[k] = raddr[k*AW +: AW];
    endtask

    // Expected read port: stored entry, or the first matching writeback.
    function automatic logic [EW-1:0] exp_read(input int k, input bit byp);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          b;
        a = m_raddr[k];
        d = m_data[a];
        b = m_busy[a];
        if (byp) begin
            for (int j = 0; j < NWB; j++) begin
                if (wb_en[j] && wb_reg[j*AW +: AW] == a && wb_tag[j*TW +: TW] == m_tag[a]) begin
                    d = wb_data[j*DW +: DW];
                    b = 1'b0;
                    break;
                end
            end
        end
        return {d, b, m_tag[a]};
    endfunction

    task automatic check_outputs();
        logic [NR-1:0] bv;
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rd_a[%0d]", k), 64'(rdata_a[k*EW +: EW]), 64'(exp_read(k, 1)));
            chk($sformatf("rd_b[%0d]", k), 64'(rdata_b[k*EW +: EW]), 64'(exp_read(k, 0)));
        end
        for (int r = 0; r < NR; r++) bv[r] = m_busy[r];
        chk("busy_vec_a", 64'(busy_vec_a), 64'(bv));
        chk("busy_vec_b", 64'(busy_vec_b), 64'(bv));
    endtask

    // Inputs are set by the caller just after a posedge; check at negedge,
    // then let the edge consume the inputs and advance the model.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle();
        reset = 0; flush = 0; al_en = '0; wb_en = '0;
    endtask

    task automatic idle_c();
        flush_c = 0; al_en_c = '0; wb_en_c = '0;
    endtask

    task automatic rand_inputs();
        int r;
        reset = ($urandom_range(0, 99) == 0);
        flush = ($urandom_range(0, 19) == 0);
        for (int k = 0; k < NRD; k++) raddr[k*AW +: AW] = AW'($urandom_range(0, NR-1));
        for (int i = 0; i < NAL; i++) begin
            al_en[i] = ($urandom_range(0, 2) == 0);
            al_reg[i*AW +: AW] = AW'($urandom_range(0, NR-1));
            al_tag[i*TW +: TW] = TW'($urandom_range(0, 7));
        end
        for (int j = 0; j < NWB; j++) begin
            wb_en[j] = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 1) ? int'(m_raddr[$urandom_range(0, NRD-1)]) : $urandom_range(0, NR-1);
            wb_reg[j*AW +: AW] = AW'(r);
            wb_data[j*DW +: DW] = DW'($urandom);
            wb_tag[j*TW +: TW] = $urandom_range(0, 2) != 0 ? m_tag[r] : TW'($urandom_range(0, 7));
        end
    endtask

    initial begin
        reset = 1; flush = 0; raddr = '0;
        al_en = '0; al_reg = '0; al_tag = '0;
        wb_en = '0; wb_reg = '0; wb_data = '0; wb_tag = '0;
        idle_c(); raddr_c = '0; al_reg_c = '0; al_tag_c = '0;
        wb_reg_c = '0; wb_data_c = '0; wb_tag_c = '0;
        for (int r = 0; r < NR; r++) begin
            m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        for (int k = 0; k < NRD; k++) m_raddr[k] = '0;
        @(posedge clk);
        #1;
        idle();
        cycle();

        // Allocate r3 tag 5, then matching writeback.
        al_en[0] = 1; al_reg[0 +: AW] = 3'd3; al_tag[0 +: TW] = 6'd5;
        cycle();
        idle();
        wb_en[0] = 1; wb_reg[0 +: AW] = 3'd3; wb_tag[0 +: TW] = 6'd5; wb_data[0 +: DW] = 16'hBEEF;
        raddr[0 +: AW] = 3'd3;
        cycle();
        idle();
        #1;
        chk("alloc_wb_r3", 64'(rdata_a[0 +: EW]), 64'({16'hBEEF, 1'b0, 6'd5}));

        // Re-allocate, then stale writeback tag 4: busy stays set.
        al_en[0] = 1; al_reg[0 +: AW] = 3'd3; al_tag[0 +: TW] = 6'd5;
        cycle();
        idle();
        wb_en[0] = 1; wb_reg[0 +: AW] = 3'd3; wb_tag[0 +: TW] = 6'd4; wb_data[0 +: DW] = 16'hBEEF;
        cycle();
        idle();
        #1;
        chk("stale_wb_r3", 64'(rdata_a[0 +: EW]), 64'({16'hBEEF, 1'b1, 6'd5}));

        // Two allocates to r2 (youngest wins) plus writeback with the old tag.
        al_en = 4'b1001;
        al_reg[0*AW +: AW] = 3'd2; al_tag[0*TW +: TW] = 6'd7;
        al_reg[3*AW +: AW] = 3'd2; al_tag[3*TW +: TW] = 6'd9;
        wb_en[0] = 1; wb_reg[0 +: AW] = 3'd2; wb_tag[0 +: TW] = 6'd0; wb_data[0 +: DW] = 16'h5555;
        raddr[0 +: AW] = 3'd2;
        cycle();
        idle();
        #1;
        chk("alloc_collide_r2", 64'(rdata_a[0 +: EW]), 64'({16'h5555, 1'b1, 6'd9}));

        // Bypass on r1 in the read-output cycle.
        al_en[0] = 1; al_reg[0 +: AW] = 3'd1; al_tag[0 +: TW] = 6'd12;
        cycle();
        idle();
        raddr[0 +: AW] = 3'd1;
        cycle();
        wb_en[0] = 1; wb_reg[0 +: AW] = 3'd1; wb_tag[0 +: TW] = 6'd12; wb_data[0 +: DW] = 16'h1234;
        #1;
        chk("bypass_on", 64'(rdata_a[0 +: EW]), 64'({16'h1234, 1'b0, 6'd12}));
        chk("bypass_off", 64'(rdata_b[0 +: EW]), 64'({16'h0000, 1'b1, 6'd12}));
        cycle();
        idle();

        // Flush against a same-edge allocate.
        al_en = 4'b1111;
        for (int i = 0; i < NAL; i++) begin
            al_reg[i*AW +: AW] = AW'(i + 1);
            al_tag[i*TW +: TW] = TW'(i + 1);
        end
        cycle();
        idle();
        al_en[0] = 1; al_reg[0 +: AW] = 3'd5; al_tag[0 +: TW] = 6'd5;
        cycle();
        idle();
        #1;
        chk("busy_pre_flush", 64'(busy_vec_a), 64'(8'h3E));
        flush = 1;
        al_en[0] = 1; al_reg[0 +: AW] = 3'd6; al_tag[0 +: TW] = 6'd33;
        raddr[0 +: AW] = 3'd6;
        cycle();
        idle();
        #1;
        chk("busy_post_flush", 64'(busy_vec_a), 64'(8'h00));
        chk("flush_alloc_r6", 64'(rdata_a[0 +: EW]), 64'({16'h0000, 1'b0, 6'd33}));

        // Zero-register instance: writes/allocates to r0 ignored, others not.
        al_en_c = 4'b0011;
        al_reg_c[0*AWC +: AWC] = 5'd0; al_tag_c[0*TW +: TW] = 6'd7;
        al_reg_c[1*AWC +: AWC] = 5'd5; al_tag_c[1*TW +: TW] = 6'd3;
        wb_en_c = 3'b011;
        wb_reg_c[0*AWC +: AWC] = 5'd0; wb_data_c[0*DWC +: DWC] = 32'hFFFF_FFFF; wb_tag_c[0*TW +: TW] = 6'd0;
        wb_reg_c[1*AWC +: AWC] = 5'd9; wb_data_c[1*DWC +: DWC] = 32'hA5A5_A5A5; wb_tag_c[1*TW +: TW] = 6'd0;
        raddr_c[0*AWC +: AWC] = 5'd0;
        raddr_c[1*AWC +: AWC] = 5'd5;
        raddr_c[2*AWC +: AWC] = 5'd9;
        cycle();
        idle_c();
        #1;
        chk("zr_r0", 64'(rdata_c[0*EWC +: EWC]), 64'(0));
        chk("zr_r5", 64'(rdata_c[1*EWC +: EWC]), 64'({32'h0, 1'b1, 6'd3}));
        chk("zr_r9", 64'(rdata_c[2*EWC +: EWC]), 64'({32'hA5A5_A5A5, 1'b0, 6'd0}));
        chk("zr_busy_vec", 64'(busy_vec_c), 64'(32'h0000_0020));
        wb_en_c = 3'b011;
        wb_reg_c[0*AWC +: AWC] = 5'd0; wb_data_c[0*DWC +: DWC] = 32'hFFFF_FFFF; wb_tag_c[0*TW +: TW] = 6'd0;
        wb_reg_c[1*AWC +: AWC] = 5'd9; wb_data_c[1*DWC +: DWC] = 32'h1234_5678; wb_tag_c[1*TW +: TW] = 6'd0;
        #1;
        chk("zr_r0_no_bypass", 64'(rdata_c[0*EWC +: EWC]), 64'(0));
        chk("zr_r9_bypass", 64'(rdata_c[2*EWC +: EWC]), 64'({32'h1234_5678, 1'b0, 6'd0}));
        cycle();
        idle_c();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle();
        end

        // Reset from random state, then read every register.
        rand_inputs();
        reset = 1;
        cycle();
        idle();
        for (int k = 0; k < NRD; k++) raddr[k*AW +: AW] = AW'(k);
        #1;
        chk("rst_busy_vec", 64'(busy_vec_a), 64'(0));
        chk("rst_rdata_r0", 64'(rdata_a), 64'(0));
        cycle();
        #1;
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rst_read_r%0d", k), 64'(rdata_a[k*EW +: EW]), 64'(0));
        end
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
